// File: rtl/colcap_pkg.sv
// Shared types and defaults for the keypad column capture block.
// Holds the FSM state encoding, the default WIDTH / STABLE_CYCLES values and
// the helper that sizes the stability counter.
package colcap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  localparam int DEF_WIDTH         = 4;
  localparam int DEF_STABLE_CYCLES = 3;

  // Bits needed to hold the values 0..n. Floors at 1 so the counter is never zero-width.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/stable_counter.sv
// Saturating match counter for the column capture debounce.
// Ports: clk, reset (sync, active-high), clear (->0), load (->1), inc (+1, saturating at MAX),
//        reached (the next inc brings the count to MAX).
// Priority: reset > clear > load > inc. The count never wraps.
module stable_counter #(
  parameter int MAX = 3,
  parameter int W   = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic load,
  input  logic inc,
  output logic reached
);

  logic [W-1:0] cnt;
  logic [W:0]   cnt_plus1;

  assign cnt_plus1 = {1'b0, cnt} + {{W{1'b0}}, 1'b1};
  assign reached   = (cnt_plus1 == (W+1)'(MAX));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(1);
    end else if (inc) begin
      if (cnt != W'(MAX)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/col_capture.sv
// Keypad column capture: accepts a column value once it is seen on STABLE_CYCLES consecutive
// enabled samples, then holds it in colout with valid high until the consumer acks.
// Ports: clk, reset (sync, active-high), colen (sample enable), colin[WIDTH] (raw columns,
//        1 = active), ack (consumer acknowledge), colout[WIDTH], valid, busy (settling),
//        multi_err (rejected multi-bit sample pulse). All outputs registered.
// Optional: define COLCAP_ONEHOT_EN to accept only one-hot samples and flag multi-bit ones;
//           without it any nonzero sample qualifies and multi_err is tied low.
module col_capture
  import colcap_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             colen,
  input  logic [WIDTH-1:0] colin,
  input  logic             ack,
  output logic [WIDTH-1:0] colout,
  output logic             valid,
  output logic             busy,
  output logic             multi_err
);

  localparam int CW = cnt_width(STABLE_CYCLES);

  state_t           state, state_n;
  logic [WIDTH-1:0] cand, cand_n;
  logic [WIDTH-1:0] colout_n;
  logic             valid_n;
  logic             busy_n;
  logic             err_n;
  logic             cnt_clear, cnt_load, cnt_inc;
  logic             reached;
  logic             qual;
  logic             multi;

`ifdef COLCAP_ONEHOT_EN
  assign qual  = $onehot(colin);
  assign multi = (colin != '0) && !$onehot(colin);
`else
  assign qual  = (colin != '0);
  assign multi = 1'b0;
`endif

  stable_counter #(
    .MAX (STABLE_CYCLES),
    .W   (CW)
  ) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .load    (cnt_load),
    .inc     (cnt_inc),
    .reached (reached)
  );

  always_comb begin
    state_n   = state;
    cand_n    = cand;
    colout_n  = colout;
    valid_n   = valid;
    err_n     = 1'b0;
    cnt_clear = 1'b0;
    cnt_load  = 1'b0;
    cnt_inc   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (colen) begin
          if (multi) begin
            err_n = 1'b1;
          end else if (qual) begin
            cand_n   = colin;
            cnt_load = 1'b1;
            // A single matching sample is already stable: capture on this edge.
            if (STABLE_CYCLES == 1) begin
              colout_n = colin;
              valid_n  = 1'b1;
              state_n  = ST_HOLD;
            end else begin
              state_n = ST_SETTLE;
            end
          end
        end
      end

      ST_SETTLE: begin
        if (colen && qual) begin
          if (colin == cand) begin
            cnt_inc = 1'b1;
            if (reached) begin
              colout_n = cand;
              valid_n  = 1'b1;
              state_n  = ST_HOLD;
            end
          end else begin
            // A different value restarts the run with itself as the new candidate.
            cand_n   = colin;
            cnt_load = 1'b1;
          end
        end else begin
          cnt_clear = 1'b1;
          state_n   = ST_IDLE;
          err_n     = colen && multi;
        end
      end

      ST_HOLD: begin
        // Inputs are ignored while holding; ack takes priority over any new sample.
        if (ack) begin
          valid_n   = 1'b0;
          cnt_clear = 1'b1;
          state_n   = ST_IDLE;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase

    busy_n = (state_n == ST_SETTLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cand      <= '0;
      colout    <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      multi_err <= 1'b0;
    end else begin
      state     <= state_n;
      cand      <= cand_n;
      colout    <= colout_n;
      valid     <= valid_n;
      busy      <= busy_n;
      multi_err <= err_n;
    end
  end

endmodule
